// File: rtl/appr_mac_acc_if.sv
// Streaming interface for appr_mac_acc: product input channel and result
// output channel, each with a valid/ready handshake.
interface appr_mac_acc_if #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40
) ();
  logic [PROD_W-1:0] prod;
  logic              in_valid;
  logic              in_ready;
  logic [ACC_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;

  // Producer/consumer side (multiplier feed and result sink)
  modport master (
    output prod, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  // Accumulator side
  modport slave (
    input  prod, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/appr_mac_acc.sv
// appr_mac_acc: accumulates a programmable number of signed products from
// the approximate Booth multiplier and presents the sum on a valid/ready
// output. Optional build macro ACC_SAT_EN: saturate the accumulator on
// signed overflow instead of wrapping.
module appr_mac_acc #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40,
  parameter int LEN_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  appr_mac_acc_if.slave    bus,
  output logic             busy,
  output logic             ovf
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]       state;
  logic [LEN_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] res;
  logic             res_valid;

  logic [ACC_W-1:0] p_ext;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] acc_nxt;
  logic             add_ovf;

  // Sign-extended add with overflow detection and optional clamp
  always_comb begin
    p_ext   = {{(ACC_W-PROD_W){bus.prod[PROD_W-1]}}, bus.prod};
    sum     = acc + p_ext;
    add_ovf = (acc[ACC_W-1] == p_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
`ifdef ACC_SAT_EN
    if (add_ovf)
      acc_nxt = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      acc_nxt = sum;
`else
    acc_nxt = sum;
`endif
  end

  assign bus.in_ready  = (state == S_ACC);
  assign bus.out_data  = res;
  assign bus.out_valid = res_valid;

  // Run control FSM, accumulator, result register and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      acc       <= '0;
      res       <= '0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      ovf       <= 1'b0;
    end else if (abort) begin
      state     <= S_IDLE;
      cnt       <= '0;
      acc       <= '0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && (len != '0)) begin
            cnt   <= len;
            acc   <= '0;
            ovf   <= 1'b0;
            state <= S_ACC;
            busy  <= 1'b1;
          end
        end
        S_ACC: begin
          if (bus.in_valid) begin
            acc <= acc_nxt;
            cnt <= cnt - 1'b1;
            if (add_ovf)
              ovf <= 1'b1;
            if (cnt == LEN_W'(1)) begin
              res       <= acc_nxt;
              res_valid <= 1'b1;
              state     <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            res_valid <= 1'b0;
            state     <= S_IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_appr_mac_acc.sv
// Directed self-checking bench for appr_mac_acc: a 40-bit instance for the
// main function and a 33-bit instance for overflow behaviour.
module tb_appr_mac_acc;

  logic clk;
  logic rst_n;

  logic       start,  abort;
  logic [7:0] len;
  logic       busy,   ovf;
  logic       start_w, abort_w;
  logic [7:0] len_w;
  logic       busy_w, ovf_w;

  int n_checks;
  int n_errors;

  appr_mac_acc_if #(.PROD_W(32), .ACC_W(40)) bus ();
  appr_mac_acc_if #(.PROD_W(32), .ACC_W(33)) bus_w ();

  appr_mac_acc #(.PROD_W(32), .ACC_W(40), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
    .bus(bus), .busy(busy), .ovf(ovf)
  );

  appr_mac_acc #(.PROD_W(32), .ACC_W(33), .LEN_W(8)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start_w), .len(len_w), .abort(abort_w),
    .bus(bus_w), .busy(busy_w), .ovf(ovf_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    start = 0; abort = 0; len = '0;
    start_w = 0; abort_w = 0; len_w = '0;
    bus.prod = '0; bus.in_valid = 0; bus.out_ready = 0;
    bus_w.prod = '0; bus_w.in_valid = 0; bus_w.out_ready = 0;
    #12;
    check("rst_busy",      64'(busy), 64'd0);
    check("rst_in_ready",  64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data",  64'(bus.out_data), 64'd0);
    check("rst_ovf",       64'(ovf), 64'd0);
    rst_n = 1'b1;
    tick();

    // Run 1: len=3, 100 + -50 + 7 = 57
    bus.out_ready = 1;
    start = 1; len = 8'd3;
    tick();
    start = 0;
    check("r1_busy", 64'(busy), 64'd1);
    check("r1_in_ready", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1; bus.prod = 32'd100;
    tick();
    bus.prod = -32'sd50;
    tick();
    check("r1_no_early_valid", 64'(bus.out_valid), 64'd0);
    bus.prod = 32'd7;
    tick();
    bus.in_valid = 0;
    check("r1_out_valid", 64'(bus.out_valid), 64'd1);
    check("r1_out_data", 64'(bus.out_data), 64'd57);
    check("r1_ovf", 64'(ovf), 64'd0);
    check("r1_hold_in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    check("r1_done_valid", 64'(bus.out_valid), 64'd0);
    check("r1_done_busy", 64'(busy), 64'd0);

    // Run 2: len=4 with in_valid toggling, 4 x 0x10000 = 0x40000
    start = 1; len = 8'd4;
    tick();
    start = 0;
    bus.prod = 32'h0001_0000;
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = ((i % 2) == 0);
      tick();
      if (i < 6) check("r2_not_done", 64'(bus.out_valid), 64'd0);
    end
    bus.in_valid = 0;
    check("r2_out_valid", 64'(bus.out_valid), 64'd1);
    check("r2_out_data", 64'(bus.out_data), 64'h00_0004_0000);
    tick();
    check("r2_done_busy", 64'(busy), 64'd0);

    // Run 3: result held with out_ready=0 while in_valid and start stay high
    bus.out_ready = 0;
    start = 1; len = 8'd1;
    tick();
    start = 0;
    bus.in_valid = 1; bus.prod = 32'd5;
    tick();
    start = 1; len = 8'd2;
    for (int i = 0; i < 5; i++) begin
      check("r3_hold_valid", 64'(bus.out_valid), 64'd1);
      check("r3_hold_data", 64'(bus.out_data), 64'd5);
      check("r3_hold_in_ready", 64'(bus.in_ready), 64'd0);
      check("r3_hold_busy", 64'(busy), 64'd1);
      tick();
    end
    bus.out_ready = 1;
    tick();
    check("r3_release_valid", 64'(bus.out_valid), 64'd0);
    check("r3_release_busy", 64'(busy), 64'd0);
    bus.in_valid = 0;
    tick();
    start = 0;
    check("r3_next_start", 64'(busy), 64'd1);
    abort = 1;
    tick();
    abort = 0;
    check("r3_abort_busy", 64'(busy), 64'd0);

    // Run 4: abort after 2 of 5 beats, then len=1 with prod=-1
    start = 1; len = 8'd5;
    tick();
    start = 0;
    bus.in_valid = 1; bus.prod = 32'd9;
    tick();
    tick();
    bus.in_valid = 0;
    abort = 1;
    tick();
    abort = 0;
    check("r4_abort_busy", 64'(busy), 64'd0);
    check("r4_abort_in_ready", 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      check("r4_no_valid", 64'(bus.out_valid), 64'd0);
      tick();
    end
    start = 1; len = 8'd1;
    tick();
    start = 0;
    bus.in_valid = 1; bus.prod = 32'hFFFF_FFFF;
    tick();
    bus.in_valid = 0;
    check("r4_out_valid", 64'(bus.out_valid), 64'd1);
    check("r4_out_data", 64'(bus.out_data), 64'h00_FF_FFFF_FFFF);
    tick();

    // Run 5: 33-bit accumulator, 4 x 0x7FFFFFFF overflows
    bus_w.out_ready = 1;
    start_w = 1; len_w = 8'd4;
    tick();
    start_w = 0;
    bus_w.in_valid = 1; bus_w.prod = 32'h7FFF_FFFF;
    for (int i = 0; i < 4; i++) tick();
    bus_w.in_valid = 0;
    check("r5_out_valid", 64'(bus_w.out_valid), 64'd1);
    check("r5_ovf", 64'(ovf_w), 64'd1);
`ifdef ACC_SAT_EN
    check("r5_out_data", 64'(bus_w.out_data), 64'h0_FFFF_FFFF);
`else
    check("r5_out_data", 64'(bus_w.out_data), 64'h1_FFFF_FFFC);
`endif
    tick();
    check("r5_ovf_sticky", 64'(ovf_w), 64'd1);

    // Run 6: asynchronous reset between clock edges mid-run
    start = 1; len = 8'd3;
    tick();
    start = 0;
    bus.in_valid = 1; bus.prod = 32'd4;
    tick();
    bus.in_valid = 0;
    #2;
    rst_n = 1'b0;
    #1;
    check("r6_busy", 64'(busy), 64'd0);
    check("r6_in_ready", 64'(bus.in_ready), 64'd0);
    check("r6_out_valid", 64'(bus.out_valid), 64'd0);
    check("r6_out_data", 64'(bus.out_data), 64'd0);
    check("r6_ovf", 64'(ovf), 64'd0);
    check("r6_w_ovf", 64'(ovf_w), 64'd0);
    check("r6_w_out_data", 64'(bus_w.out_data), 64'd0);
    #1;
    rst_n = 1'b1;
    tick();
    start = 1; len = 8'd0;
    tick();
    start = 0;
    check("r6_len0_busy", 64'(busy), 64'd0);
    check("r6_len0_in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    check("r6_len0_busy_later", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
